// File: rtl/fifo_pkg.sv
// Shared parameters, types and helpers for the FIFO read-side logic.
package fifo_pkg;

    localparam int DATA_W    = 32;   // FIFO word width
    localparam int PTR_W     = 5;    // pointer width, wrap bit included
    localparam int DEPTH     = 16;   // FIFO entries
    localparam int LO_THRESH = 150;  // low-byte limit for the range check
    localparam int HI_LIMIT  = 230;  // high-byte limit for the range check
    localparam int CNT_W     = 16;   // delivered-word counter width

    localparam int BUF_CNT_W = 2;    // occupancy width of the 2-entry output buffer

    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [BUF_CNT_W-1:0] buf_cnt_t;

    // Output buffer occupancy; the encoding doubles as the word count.
    typedef enum logic [BUF_CNT_W-1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Unread words between the two pointers; the wrap bit makes plain
    // modulo-32 subtraction give the right answer across a wrap.
    function automatic ptr_t ptr_distance(input ptr_t wr, input ptr_t rd);
        return wr - rd;
    endfunction

    // A word is out of range when both its low byte and its top byte
    // exceed their limits at the same time.
    function automatic logic word_out_of_range(input word_t w);
        return (w[7:0] > 8'(LO_THRESH)) && (w[31:24] > 8'(HI_LIMIT));
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream-side signals of the reader, bundled.
// The reader owns the master modport; the environment uses slave.
interface fifo_reader_if;
    import fifo_pkg::*;

    ptr_t  write_ptr;   // writer's pointer
    word_t data_out;    // memory read data, one cycle after Rd_enable
    logic  Rd_enable;   // memory read strobe
    ptr_t  read_ptr;    // reader's pointer, [3:0] is the read address
    logic  empty;       // no unread words
    logic  m_valid;     // downstream word available
    logic  m_ready;     // downstream accepts the word
    word_t m_data;      // downstream word

    modport master (
        input  write_ptr, data_out, m_ready,
        output Rd_enable, read_ptr, empty, m_valid, m_data
    );

    modport slave (
        output write_ptr, data_out, m_ready,
        input  Rd_enable, read_ptr, empty, m_valid, m_data
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer. Words arrive on push, leave on pop;
// head is always the oldest word held. A push and a pop in the same
// cycle keep the occupancy unchanged.
module fifo_skid_buf
    import fifo_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  word_t    data,
    input  logic     pop,
    output buf_cnt_t cnt,
    output word_t    head
);

    buf_state_e state_q, state_d;
    word_t      head_q, head_d;
    word_t      tail_q, tail_d;

    // Occupancy state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    // Next occupancy and next slot contents from push/pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case can leave a latch behind.
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_d = data;
                end else if (push) begin
                    tail_d  = data;
                    state_d = BUF_FULL;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = data;
                    else      state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Slot registers.
    // NOTE: only two words of storage, and m_data must read 0 out of
    // reset, so these are reset like ordinary flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign cnt  = buf_cnt_t'(state_q);
    assign head = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Read side of a pointer-based FIFO: issues memory reads while the
// output buffer has room (counting the read already in flight), feeds
// returned words into a two-entry buffer for a valid/ready consumer,
// counts delivered words and flags data-range and pointer overruns.
module fifo_reader
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    fifo_reader_if.master     bus,
    output logic [CNT_W-1:0]  rd_count,
    output logic              range_err,
    output logic              ptr_err
);

    ptr_t     read_ptr_q;
    logic     infl_q;        // a read was issued last cycle; its data is on data_out now
    logic     rd_en;
    logic     pop;
    buf_cnt_t buf_cnt;
    word_t    buf_head;
    logic [2:0] committed;   // buffered words plus the one in flight

    assign bus.empty   = (read_ptr_q == bus.write_ptr);
    assign bus.m_valid = (buf_cnt != '0);
    assign bus.m_data  = buf_head;
    assign pop         = bus.m_valid && bus.m_ready;

    // Issue a read only if, after this cycle's pop, the buffer still has
    // a free slot for it once everything already committed has landed.
    // Held low while reset is asserted so no read leaves during reset.
    assign committed = {1'b0, buf_cnt} + {2'b00, infl_q};
    assign rd_en     = reset && !bus.empty
                       && (committed < (3'd2 + {2'b00, pop}));

    assign bus.Rd_enable = rd_en;
    assign bus.read_ptr  = read_ptr_q;

    // Read pointer advances once per issued read, wrapping at 32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     read_ptr_q <= '0;
        else if (rd_en) read_ptr_q <= read_ptr_q + ptr_t'(1);
    end

    // Remember an issued read so its data is captured one cycle later;
    // clearing this on reset drops any read that was in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) infl_q <= 1'b0;
        else        infl_q <= rd_en;
    end

    fifo_skid_buf u_skid_buf (
        .clk   (clk),
        .reset (reset),
        .push  (infl_q),
        .data  (bus.data_out),
        .pop   (pop),
        .cnt   (buf_cnt),
        .head  (buf_head)
    );

    // Delivered-word counter, saturating at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        rd_count <= '0;
        else if (pop && (rd_count != '1))  rd_count <= rd_count + 1'b1;
    end

    // Sticky flag for a delivered word whose bytes are both out of range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     range_err <= 1'b0;
        else if (pop && word_out_of_range(bus.m_data))  range_err <= 1'b1;
    end

    // Sticky flag for the writer running more than DEPTH words ahead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr_err <= 1'b0;
        else if (ptr_distance(bus.write_ptr, read_ptr_q) > ptr_t'(DEPTH))
            ptr_err <= 1'b1;
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a 16-entry memory model answers reads
// one cycle after Rd_enable, and every delivered word is compared
// against the words written, in order.
module tb_fifo_reader;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_reader_if bus();
    logic [CNT_W-1:0] rd_count;
    logic             range_err;
    logic             ptr_err;

    fifo_reader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rd_count  (rd_count),
        .range_err (range_err),
        .ptr_err   (ptr_err)
    );

    word_t mem [DEPTH];
    word_t exp_q [$];
    ptr_t  wp;
    int    n_checks = 0;
    int    n_errors = 0;

    // Synchronous memory read port.
    always @(posedge clk) begin
        if (!reset)             bus.data_out <= '0;
        else if (bus.Rd_enable) bus.data_out <= mem[bus.read_ptr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle; a word handed over this cycle is matched against
    // the oldest word still expected.
    task automatic step();
        #3;
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) check("pop_extra", 32'(exp_q.size()), 32'd1);
            else                   check("pop_data", bus.m_data, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, checking Rd_enable and m_valid against bit i of the
    // expected patterns in cycle i.
    task automatic run_pattern(input int n, input logic [15:0] exp_rd, input logic [15:0] exp_mv);
        for (int i = 0; i < n; i++) begin
            #2;
            check($sformatf("rd_en_c%0d", i), 32'(bus.Rd_enable), 32'(exp_rd[i]));
            check($sformatf("m_valid_c%0d", i), 32'(bus.m_valid), 32'(exp_mv[i]));
            step();
        end
    endtask

    task automatic push_words(input int n, input word_t base);
        for (int i = 0; i < n; i++) begin
            mem[wp[3:0]] = base + word_t'(i);
            exp_q.push_back(base + word_t'(i));
            wp = wp + ptr_t'(1);
        end
        bus.write_ptr = wp;
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && !bus.m_valid) break;
            step();
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero_state(input string pfx);
        check({pfx, "_read_ptr"},  32'(bus.read_ptr),  32'd0);
        check({pfx, "_rd_en"},     32'(bus.Rd_enable), 32'd0);
        check({pfx, "_m_valid"},   32'(bus.m_valid),   32'd0);
        check({pfx, "_m_data"},    bus.m_data,         32'd0);
        check({pfx, "_rd_count"},  32'(rd_count),      32'd0);
        check({pfx, "_range_err"}, 32'(range_err),     32'd0);
        check({pfx, "_ptr_err"},   32'(ptr_err),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wp            = '0;
        bus.write_ptr = '0;
        bus.m_ready   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_zero_state("rst");
        check("rst_empty", 32'(bus.empty), 32'd1);
        reset = 1'b1;
        run_pattern(2, 16'b0, 16'b0);
        check("idle_empty", 32'(bus.empty), 32'd1);

        // Three words, consumer ready: reads in cycles 0-2, valid in 2-4.
        bus.m_ready = 1'b1;
        push_words(3, 32'h1111_0000);
        run_pattern(6, 16'b000111, 16'b011100);
        check("burst3_rd_count", 32'(rd_count),     32'd3);
        check("burst3_read_ptr", 32'(bus.read_ptr), 32'd3);
        check("burst3_empty",    32'(bus.empty),    32'd1);
        check("burst3_left",     32'(exp_q.size()), 32'd0);

        // Five words, consumer stalled: two reads fill the buffer, then stop.
        bus.m_ready = 1'b0;
        push_words(5, 32'h2222_0000);
        run_pattern(6, 16'b000011, 16'b111100);
        check("stall_read_ptr", 32'(bus.read_ptr),  32'd5);
        check("stall_rd_en",    32'(bus.Rd_enable), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_m_data",  bus.m_data,        32'h2222_0000);
            check("stall_m_valid", 32'(bus.m_valid),  32'd1);
        end
        drain();
        check("stall_rd_count", 32'(rd_count), 32'd8);

        // Pointer wrap: bring read_ptr to 30, then four more words.
        push_words(11, 32'h3000_0000);
        drain();
        push_words(11, 32'h3100_0000);
        drain();
        check("pre_wrap_read_ptr", 32'(bus.read_ptr), 32'd30);
        push_words(4, 32'h3200_0000);
        drain();
        check("wrap_read_ptr", 32'(bus.read_ptr), 32'd2);
        check("wrap_rd_count", 32'(rd_count),     32'd34);

        // Writer exactly DEPTH ahead is not an overrun.
        bus.m_ready = 1'b0;
        push_words(16, 32'h4000_0000);
        repeat (3) step();
        check("full_ptr_err", 32'(ptr_err),       32'd0);
        check("full_rd_en",   32'(bus.Rd_enable), 32'd0);
        drain();
        check("full_rd_count", 32'(rd_count), 32'd50);

        // Range check: each limit on its own is not a violation.
        push_words(1, 32'hE600_00A0);
        push_words(1, 32'hFF00_0096);
        drain();
        check("range_edge", 32'(range_err), 32'd0);
        push_words(1, 32'hE700_00A0);
        drain();
        check("range_hit", 32'(range_err), 32'd1);
        push_words(1, 32'h0000_0001);
        drain();
        check("range_sticky", 32'(range_err), 32'd1);
        check("range_ptr_err", 32'(ptr_err),  32'd0);

        // Writer 17 ahead flags an overrun; reset mid-burst clears everything.
        bus.m_ready   = 1'b0;
        bus.write_ptr = bus.read_ptr + ptr_t'(17);
        step();
        check("overrun_ptr_err", 32'(ptr_err), 32'd1);
        step();
        check("midburst_m_valid", 32'(bus.m_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_zero_state("midrst");
        check("midrst_empty", 32'(bus.empty), 32'd0);
        exp_q.delete();
        wp            = '0;
        bus.write_ptr = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_pattern(3, 16'b0, 16'b0);
        check("post_rst_rd_count", 32'(rd_count), 32'd0);

        // Clean restart after reset.
        push_words(2, 32'h5000_0000);
        drain();
        check("restart_rd_count", 32'(rd_count),     32'd2);
        check("restart_read_ptr", 32'(bus.read_ptr), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
